clk_edge_monitor: RTL and testbench

Receive-side companion to the clock divider: accepts a slow, asynchronous divided-clock or strobe signal, synchronizes it into the system clock domain, and converts its edges into single-cycle `tick` / `fall_tick` enables. It also measures the period in system clocks, reports frequency lock, and flags a stalled source. Game and VGA logic use it to run off clean enables instead of clocking flops from a divided clock.

---
 rtl/clk_edge_monitor.sv | 147 ++++++++++++++
 tb/tb_clk_edge_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_edge_monitor.sv
// Turns an asynchronous slow clock/strobe into single-cycle edge enables and tracks its period, lock and stall status.
// Edge enables appear SYNC_STAGES+1 clocks after the input is first sampled; there is no backpressure and every synchronized edge gives one pulse.
module clk_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 16,
    parameter int TIMEOUT     = 1000,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                slow_in,
    output logic                tick,
    output logic                fall_tick,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                stalled,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        FIRST  = 2'd1,
        TRACK  = 2'd2,
        STALL  = 2'd3
    } state_t;

    localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
    localparam logic [3:0]          LOCK_V    = 4'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dat;
    logic                   prev_q;
    logic                   rise;
    logic                   fall;

    logic [PERIOD_W-1:0]    cnt;
    logic [PERIOD_W-1:0]    cnt_inc;
    logic                   timed_out;

    state_t                 cur_state;
    state_t                 nxt_state;
    logic [3:0]             match;
    logic [3:0]             match_nxt;
    logic [PERIOD_W-1:0]    period_nxt;
    logic                   period_valid_nxt;
    logic                   locked_nxt;

    assign sync_dat  = sync_q[SYNC_STAGES-1];
    assign rise      = sync_dat & ~prev_q;
    assign fall      = ~sync_dat & prev_q;
    assign cnt_inc   = cnt + {{(PERIOD_W-1){1'b0}}, 1'b1};
    assign timed_out = (cnt == TIMEOUT_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            tick      <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], slow_in};
            prev_q    <= sync_dat;
            tick      <= rise;
            fall_tick <= fall;
        end
    end

    // Saturates at TIMEOUT so a dead source parks the counter instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (!timed_out) begin
            cnt <= cnt_inc;
        end
    end

    always_comb begin
        nxt_state        = cur_state;
        period_nxt       = period;
        period_valid_nxt = 1'b0;
        match_nxt        = match;
        case (cur_state)
            SEARCH: begin
                if (rise) begin
                    nxt_state = FIRST;
                    match_nxt = 4'd0;
                end else if (timed_out) begin
                    nxt_state = STALL;
                end
            end
            FIRST: begin
                if (rise) begin
                    nxt_state        = TRACK;
                    period_nxt       = cnt_inc;
                    period_valid_nxt = 1'b1;
                    match_nxt        = 4'd0;
                end else if (timed_out) begin
                    nxt_state = STALL;
                end
            end
            TRACK: begin
                if (rise) begin
                    period_nxt       = cnt_inc;
                    period_valid_nxt = 1'b1;
                    if (cnt_inc == period) begin
                        match_nxt = (match >= LOCK_V) ? LOCK_V : match + 4'd1;
                    end else begin
                        match_nxt = 4'd0;
                    end
                end else if (timed_out) begin
                    nxt_state = STALL;
                end
            end
            STALL: begin
                // The period across a stall is meaningless, so no update here.
                if (rise) begin
                    nxt_state = FIRST;
                    match_nxt = 4'd0;
                end
            end
        endcase
        locked_nxt = (nxt_state == TRACK) && (match_nxt == LOCK_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= SEARCH;
            period       <= '0;
            period_valid <= 1'b0;
            match        <= 4'd0;
            locked       <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            period       <= period_nxt;
            period_valid <= period_valid_nxt;
            match        <= match_nxt;
            locked       <= locked_nxt;
        end
    end

    assign state   = cur_state;
    assign stalled = (cur_state == STALL);

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Directed bench for clk_edge_monitor with TIMEOUT=100; each task drives one scenario and checks inline.
module tb_clk_edge_monitor;

    localparam int PW = 16;

    logic          clk;
    logic          rst_n;
    logic          slow_in;
    logic          tick;
    logic          fall_tick;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          stalled;
    logic [1:0]    state;

    int passed = 0;
    int total  = 0;

    int cyc, nt, nf, orphan, dbl, nstall, last_tick;
    logic prev_tick, prev_stl;
    logic          rec_pv   [32];
    logic [PW-1:0] rec_per  [32];
    logic [1:0]    rec_st   [32];
    logic          rec_lk   [32];
    logic          rec_pstl [32];
    int            rec_tc   [32];
    int            rec_fc   [32];

    clk_edge_monitor #(
        .SYNC_STAGES(2),
        .PERIOD_W(PW),
        .TIMEOUT(100),
        .LOCK_COUNT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .slow_in(slow_in),
        .tick(tick),
        .fall_tick(fall_tick),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
        .stalled(stalled),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_rec();
        cyc = 0; nt = 0; nf = 0; orphan = 0; dbl = 0; nstall = 0; last_tick = 0;
        prev_tick = 1'b0; prev_stl = stalled;
    endtask

    // One clock, then record what the outputs did on that edge.
    task automatic clk_step();
        @(posedge clk);
        #1;
        cyc++;
        if (period_valid && !tick) orphan++;
        if (tick && prev_tick) dbl++;
        if (stalled) nstall++;
        if (tick) last_tick = cyc;
        if (tick && nt < 32) begin
            rec_pv[nt]   = period_valid;
            rec_per[nt]  = period;
            rec_st[nt]   = state;
            rec_lk[nt]   = locked;
            rec_pstl[nt] = prev_stl;
            rec_tc[nt]   = cyc;
            nt++;
        end
        if (fall_tick && nf < 32) begin
            rec_fc[nf] = cyc;
            nf++;
        end
        prev_tick = tick;
        prev_stl  = stalled;
    endtask

    task automatic drive(input int pre_lo, input int hi, input int lo, input int nper);
        for (int i = 0; i < pre_lo; i++) begin slow_in = 1'b0; clk_step(); end
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < hi; i++) begin slow_in = 1'b1; clk_step(); end
            for (int i = 0; i < lo; i++) begin slow_in = 1'b0; clk_step(); end
        end
    endtask

    task automatic release_reset();
        slow_in = 1'b0;
        clk_step();
        rst_n = 1'b1;
        clk_step();
        clk_step();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        slow_in = 1'b0;
        clear_rec();
        for (int i = 0; i < 8; i++) begin
            slow_in = ~slow_in;
            clk_step();
            total++;
            if ({tick, fall_tick, period_valid, locked, stalled, state, period} !== '0)
                $display("FAIL reset_hold cyc %0d got %0h want 0", i,
                         {tick, fall_tick, period_valid, locked, stalled, state, period});
            else passed++;
        end
        release_reset();
        total++;
        if (state !== 2'd0) $display("FAIL reset_release_state got %0d want 0", state);
        else passed++;
    endtask

    task automatic test_square();
        clear_rec();
        drive(0, 4, 4, 6);
        total++; if (nt !== 6) $display("FAIL sq_ticks got %0d want 6", nt); else passed++;
        total++; if (nf !== 6) $display("FAIL sq_falls got %0d want 6", nf); else passed++;
        total++; if (rec_tc[0] !== 3) $display("FAIL sq_first_tick_cyc got %0d want 3", rec_tc[0]); else passed++;
        total++; if (rec_tc[1] - rec_tc[0] !== 8) $display("FAIL sq_tick_spacing got %0d want 8", rec_tc[1] - rec_tc[0]); else passed++;
        total++; if (rec_pv[0] !== 1'b0) $display("FAIL sq_rise1_pv got %0d want 0", rec_pv[0]); else passed++;
        total++; if (rec_st[0] !== 2'd1) $display("FAIL sq_rise1_state got %0d want 1", rec_st[0]); else passed++;
        total++; if (rec_pv[1] !== 1'b1) $display("FAIL sq_rise2_pv got %0d want 1", rec_pv[1]); else passed++;
        total++; if (rec_per[1] !== 16'd8) $display("FAIL sq_rise2_period got %0d want 8", rec_per[1]); else passed++;
        total++; if (rec_st[1] !== 2'd2) $display("FAIL sq_rise2_state got %0d want 2", rec_st[1]); else passed++;
        total++; if (rec_lk[4] !== 1'b0) $display("FAIL sq_rise5_locked got %0d want 0", rec_lk[4]); else passed++;
        total++; if (rec_lk[5] !== 1'b1) $display("FAIL sq_rise6_locked got %0d want 1", rec_lk[5]); else passed++;
        total++; if (rec_per[5] !== 16'd8) $display("FAIL sq_rise6_period got %0d want 8", rec_per[5]); else passed++;
        total++; if (orphan !== 0) $display("FAIL sq_pv_without_tick got %0d want 0", orphan); else passed++;
        total++; if (dbl !== 0) $display("FAIL sq_tick_width got %0d want 0", dbl); else passed++;
    endtask

    task automatic test_period_change();
        clear_rec();
        drive(4, 4, 8, 5);
        total++; if (nt !== 5) $display("FAIL chg_ticks got %0d want 5", nt); else passed++;
        total++; if (rec_pv[0] !== 1'b1) $display("FAIL chg_rise1_pv got %0d want 1", rec_pv[0]); else passed++;
        total++; if (rec_per[0] !== 16'd12) $display("FAIL chg_rise1_period got %0d want 12", rec_per[0]); else passed++;
        total++; if (rec_lk[0] !== 1'b0) $display("FAIL chg_rise1_locked got %0d want 0", rec_lk[0]); else passed++;
        total++; if (rec_st[0] !== 2'd2) $display("FAIL chg_rise1_state got %0d want 2", rec_st[0]); else passed++;
        total++; if (rec_lk[3] !== 1'b0) $display("FAIL chg_rise4_locked got %0d want 0", rec_lk[3]); else passed++;
        total++; if (rec_lk[4] !== 1'b1) $display("FAIL chg_rise5_locked got %0d want 1", rec_lk[4]); else passed++;
        total++; if (rec_per[4] !== 16'd12) $display("FAIL chg_rise5_period got %0d want 12", rec_per[4]); else passed++;
    endtask

    task automatic test_async_reset();
        total++; if (locked !== 1'b1) $display("FAIL areset_pre_locked got %0d want 1", locked); else passed++;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({tick, fall_tick, period_valid, locked, stalled, state, period} !== '0)
            $display("FAIL areset_immediate got %0h want 0",
                     {tick, fall_tick, period_valid, locked, stalled, state, period});
        else passed++;
        release_reset();
    endtask

    task automatic test_stall();
        clear_rec();
        drive(0, 4, 4, 6);
        total++; if (rec_lk[5] !== 1'b1) $display("FAIL stall_pre_locked got %0d want 1", rec_lk[5]); else passed++;
        slow_in = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cyc >= last_tick + 100) break;
            clk_step();
        end
        total++; if (cyc !== last_tick + 100) $display("FAIL stall_wait_bound got %0d want %0d", cyc, last_tick + 100); else passed++;
        total++; if (stalled !== 1'b0) $display("FAIL stall_r100_stalled got %0d want 0", stalled); else passed++;
        total++; if (state !== 2'd2) $display("FAIL stall_r100_state got %0d want 2", state); else passed++;
        total++; if (locked !== 1'b1) $display("FAIL stall_r100_locked got %0d want 1", locked); else passed++;
        clk_step();
        total++; if (stalled !== 1'b1) $display("FAIL stall_r101_stalled got %0d want 1", stalled); else passed++;
        total++; if (state !== 2'd3) $display("FAIL stall_r101_state got %0d want 3", state); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL stall_r101_locked got %0d want 0", locked); else passed++;
        clear_rec();
        drive(0, 4, 4, 2);
        total++; if (nt !== 2) $display("FAIL resume_ticks got %0d want 2", nt); else passed++;
        total++; if (rec_pstl[0] !== 1'b1) $display("FAIL resume_stalled_before got %0d want 1", rec_pstl[0]); else passed++;
        total++; if (rec_st[0] !== 2'd1) $display("FAIL resume_rise1_state got %0d want 1", rec_st[0]); else passed++;
        total++; if (rec_pv[0] !== 1'b0) $display("FAIL resume_rise1_pv got %0d want 0", rec_pv[0]); else passed++;
        total++; if (rec_pv[1] !== 1'b1) $display("FAIL resume_rise2_pv got %0d want 1", rec_pv[1]); else passed++;
        total++; if (rec_per[1] !== 16'd8) $display("FAIL resume_rise2_period got %0d want 8", rec_per[1]); else passed++;
        total++; if (rec_st[1] !== 2'd2) $display("FAIL resume_rise2_state got %0d want 2", rec_st[1]); else passed++;
        total++; if (orphan !== 0) $display("FAIL resume_pv_without_tick got %0d want 0", orphan); else passed++;
    endtask

    task automatic test_timeout_boundary();
        clear_rec();
        drive(0, 1, 100, 4);
        total++; if (nt !== 4) $display("FAIL bnd_ticks got %0d want 4", nt); else passed++;
        total++; if (rec_per[1] !== 16'd101) $display("FAIL bnd_rise2_period got %0d want 101", rec_per[1]); else passed++;
        total++; if (rec_per[3] !== 16'd101) $display("FAIL bnd_rise4_period got %0d want 101", rec_per[3]); else passed++;
        total++; if (rec_pv[2] !== 1'b1) $display("FAIL bnd_rise3_pv got %0d want 1", rec_pv[2]); else passed++;
        total++; if (rec_st[3] !== 2'd2) $display("FAIL bnd_rise4_state got %0d want 2", rec_st[3]); else passed++;
        total++; if (nstall !== 0) $display("FAIL bnd_stall_cycles got %0d want 0", nstall); else passed++;
    endtask

    task automatic test_short_pulse();
        clear_rec();
        drive(0, 1, 7, 4);
        total++; if (nt !== 4) $display("FAIL pulse_ticks got %0d want 4", nt); else passed++;
        total++; if (nf !== 4) $display("FAIL pulse_falls got %0d want 4", nf); else passed++;
        total++; if (dbl !== 0) $display("FAIL pulse_tick_width got %0d want 0", dbl); else passed++;
        total++; if (rec_tc[1] - rec_tc[0] !== 8) $display("FAIL pulse_tick_spacing got %0d want 8", rec_tc[1] - rec_tc[0]); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rec_fc[i] - rec_tc[i] !== 1)
                $display("FAIL pulse_fall_gap%0d got %0d want 1", i, rec_fc[i] - rec_tc[i]);
            else passed++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        slow_in = 1'b0;
        test_reset();
        test_square();
        test_period_change();
        test_async_reset();
        test_stall();
        test_timeout_boundary();
        test_short_pulse();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
